// File: rtl/control_multi.sv
// Multi-cycle MIPS control unit: sequences fetch, decode, execute, memory and
// writeback over a shared memory with a ready handshake and sticky error flags.
module control_multi #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       instr_zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BrType,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Shamt,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       err_illegal,
  output logic       err_timeout,
  output logic [3:0] state
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_IEX   = 4'd10,
    S_IWB   = 4'd11,
    S_HALT  = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_timeout_q, err_timeout_d;
  logic             mem_wait, timeout_hit, shift_fn;

  logic       pc_write_q, pc_write_d, pc_write_cond_q, pc_write_cond_d;
  logic       br_type_q, br_type_d, iord_q, iord_d;
  logic       mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic       alu_src_a_q, alu_src_a_d, shamt_q, shamt_d;
  logic       reg_dst_q, reg_dst_d, mem_to_reg_q, mem_to_reg_d;
  logic       reg_write_q, reg_write_d, done_q, done_d;
  logic [1:0] pc_source_q, pc_source_d, alu_src_b_q, alu_src_b_d, alu_op_q, alu_op_d;
  logic       fetch_c;

  assign mem_wait    = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  assign timeout_hit = mem_wait && !mem_ready && (cnt_q == CNT_LAST);
  assign shift_fn    = (funct == FN_SLL) || (funct == FN_SRL);

  // Next state, wait counter and sticky error flags.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    if (!run_q) begin
      state_d = S_IF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IF:    if (mem_ready) state_d = S_ID;
        S_ID: begin
          case (opcode)
            OP_RTYPE:       state_d = instr_zero ? S_IF : S_REX;
            OP_LW, OP_SW:   state_d = S_MADDR;
            OP_BEQ, OP_BGTZ: state_d = S_BR;
            OP_J:           state_d = S_JMP;
            OP_ADDIU:       state_d = S_IEX;
            default: begin
              state_d       = S_HALT;
              err_illegal_d = 1'b1;
            end
          endcase
        end
        S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
        S_MRD:   if (mem_ready) state_d = S_MWB;
        S_MWR:   if (mem_ready) state_d = S_IF;
        S_REX:   state_d = S_RWB;
        S_IEX:   state_d = S_IWB;
        S_MWB, S_RWB, S_BR, S_JMP, S_IWB: state_d = S_IF;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_HALT;
      endcase
      if (timeout_hit) begin
        state_d       = S_HALT;
        err_timeout_d = 1'b1;
      end
      // Counter restarts on every state change, so entry to a wait state sees 0.
      if (state_d != state_q) cnt_d = '0;
      else if (mem_wait && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Moore outputs decoded from the upcoming state so they register in step.
  always_comb begin
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    br_type_d       = 1'b0;
    pc_source_d     = 2'b00;
    iord_d          = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    alu_op_d        = 2'b00;
    shamt_d         = 1'b0;
    reg_dst_d       = 1'b0;
    mem_to_reg_d    = 1'b0;
    reg_write_d     = 1'b0;
    done_d          = 1'b0;
    case (state_d)
      S_IF: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      S_ID:    alu_src_b_d = 2'b11;
      S_MADDR, S_IEX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_MRD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MWB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        done_d       = 1'b1;
      end
      S_MWR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      S_REX: begin
        alu_op_d    = 2'b10;
        alu_src_a_d = 1'b1;
      end
      S_RWB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        done_d      = 1'b1;
      end
      S_BR: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = 2'b01;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
        br_type_d       = (opcode == OP_BGTZ);
        done_d          = 1'b1;
      end
      S_JMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
        done_d      = 1'b1;
      end
      S_IWB: begin
        reg_write_d = 1'b1;
        done_d      = 1'b1;
      end
      default: ;
    endcase
    if (((state_d == S_REX) || (state_d == S_RWB)) && shift_fn) begin
      shamt_d     = 1'b1;
      alu_src_b_d = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IF;
      run_q           <= 1'b0;
      cnt_q           <= '0;
      err_illegal_q   <= 1'b0;
      err_timeout_q   <= 1'b0;
      pc_write_q      <= 1'b0;
      pc_write_cond_q <= 1'b0;
      br_type_q       <= 1'b0;
      pc_source_q     <= 2'b00;
      iord_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      alu_src_a_q     <= 1'b0;
      alu_src_b_q     <= 2'b00;
      alu_op_q        <= 2'b00;
      shamt_q         <= 1'b0;
      reg_dst_q       <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      reg_write_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_q           <= 1'b1;
      cnt_q           <= cnt_d;
      err_illegal_q   <= err_illegal_d;
      err_timeout_q   <= err_timeout_d;
      pc_write_q      <= pc_write_d;
      pc_write_cond_q <= pc_write_cond_d;
      br_type_q       <= br_type_d;
      pc_source_q     <= pc_source_d;
      iord_q          <= iord_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      alu_src_a_q     <= alu_src_a_d;
      alu_src_b_q     <= alu_src_b_d;
      alu_op_q        <= alu_op_d;
      shamt_q         <= shamt_d;
      reg_dst_q       <= reg_dst_d;
      mem_to_reg_q    <= mem_to_reg_d;
      reg_write_q     <= reg_write_d;
      done_q          <= done_d;
    end
  end

  // Handshake-gated strobes: fetch commit and store/NOP completion.
  assign fetch_c     = run_q && (state_q == S_IF);
  assign IRWrite     = fetch_c && mem_ready;
  assign PCWrite     = pc_write_q || (fetch_c && mem_ready);
  assign instr_done  = done_q || ((state_q == S_MWR) && mem_ready)
                     || ((state_q == S_ID) && (opcode == OP_RTYPE) && instr_zero);

  assign PCWriteCond = pc_write_cond_q;
  assign BrType      = br_type_q;
  assign PCSource    = pc_source_q;
  assign IorD        = iord_q;
  assign MemRead     = mem_read_q;
  assign MemWrite    = mem_write_q;
  assign ALUSrcA     = alu_src_a_q;
  assign ALUSrcB     = alu_src_b_q;
  assign ALUOp       = alu_op_q;
  assign Shamt       = shamt_q;
  assign RegDst      = reg_dst_q;
  assign MemtoReg    = mem_to_reg_q;
  assign RegWrite    = reg_write_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign state       = 4'(state_q);

endmodule

// File: tb/tb_control_multi.sv
// Bench for control_multi: per-instruction expected state sequences and
// per-signal output rules, driven with random handshake timing.
module tb_control_multi;

  localparam int unsigned TMO = 16;

  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3;
  localparam logic [3:0] S_MWB = 4'd4, S_MWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7;
  localparam logic [3:0] S_BR = 4'd8, S_JMP = 4'd9, S_IEX = 4'd10, S_IWB = 4'd11;
  localparam logic [3:0] S_HALT = 4'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       instr_zero, mem_ready;
  logic       PCWrite, PCWriteCond, BrType, IorD, MemRead, MemWrite, IRWrite;
  logic       ALUSrcA, Shamt, RegDst, MemtoReg, RegWrite, instr_done;
  logic       err_illegal, err_timeout;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
  logic [18:0] ctl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] st;
    bit         waiting;
    bit         last;
    bit         ei;
    bit         et;
  } step_t;

  step_t plan[$];

  always #5 clk = ~clk;

  control_multi #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .instr_zero(instr_zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BrType(BrType),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Shamt(Shamt), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instr_done(instr_done), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .state(state)
  );

  assign ctl = {PCWrite, PCWriteCond, BrType, PCSource, IorD, MemRead, MemWrite, IRWrite,
                ALUSrcA, ALUSrcB, ALUOp, Shamt, RegDst, MemtoReg, RegWrite, instr_done};

  // Each control signal stated as the set of states (and conditions) asserting it.
  function automatic logic [18:0] expect_ctl(input logic [3:0] st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic zero,
                                             input logic mr);
    logic fetch_ok, shift, rpath;
    logic pcw, pcwc, brt, iord, mrd, mwr, irw, asa, sh, rdst, m2r, rw, done;
    logic [1:0] pcs, asb, aop;
    fetch_ok = (st == S_IF) && mr;
    shift    = (fn == 6'd0) || (fn == 6'd2);
    rpath    = (st == S_REX) || (st == S_RWB);
    pcw      = fetch_ok || (st == S_JMP);
    pcwc     = (st == S_BR);
    brt      = (st == S_BR) && (op == 6'd7);
    pcs      = (st == S_BR) ? 2'b01 : (st == S_JMP) ? 2'b10 : 2'b00;
    iord     = (st == S_MRD) || (st == S_MWR);
    mrd      = (st == S_IF) || (st == S_MRD);
    mwr      = (st == S_MWR);
    irw      = fetch_ok;
    asa      = st inside {S_MADDR, S_REX, S_BR, S_IEX};
    if (st == S_IF) asb = 2'b01;
    else if (st == S_ID) asb = 2'b11;
    else if ((st inside {S_MADDR, S_IEX}) || (rpath && shift)) asb = 2'b10;
    else asb = 2'b00;
    aop      = (st == S_REX) ? 2'b10 : (st == S_BR) ? 2'b01 : 2'b00;
    sh       = rpath && shift;
    rdst     = (st == S_RWB);
    m2r      = (st == S_MWB);
    rw       = st inside {S_MWB, S_RWB, S_IWB};
    done     = (st inside {S_MWB, S_RWB, S_BR, S_JMP, S_IWB}) || ((st == S_MWR) && mr)
             || ((st == S_ID) && (op == 6'd0) && zero);
    return {pcw, pcwc, brt, pcs, iord, mrd, mwr, irw, asa, asb, aop, sh, rdst, m2r, rw, done};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd7, 6'd9, 6'd35, 6'd43};
  endfunction

  task automatic add(input logic [3:0] st, input bit w, input bit l, input bit ei, input bit et);
    step_t s;
    s.st = st; s.waiting = w; s.last = l; s.ei = ei; s.et = et;
    plan.push_back(s);
  endtask

  // n not-ready cycles, then either the ready cycle or a timeout into HALT.
  task automatic add_wait(input logic [3:0] st, input int n, input bit tmo);
    for (int i = 0; i < n; i++) add(st, 1'b1, 1'b0, 1'b0, 1'b0);
    if (tmo) for (int i = 0; i < 3; i++) add(S_HALT, 1'b0, 1'b0, 1'b0, 1'b1);
    else add(st, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic build_plan(input logic [5:0] op, input logic zero, input int wi,
                            input int wm, input bit tmo_if, input bit tmo_mem);
    plan.delete();
    add_wait(S_IF, wi, tmo_if);
    if (tmo_if) return;
    add(S_ID, 1'b0, 1'b0, 1'b0, 1'b0);
    if (op == 6'd0 && zero) return;
    case (op)
      6'd0: begin
        add(S_REX, 1'b0, 1'b0, 1'b0, 1'b0);
        add(S_RWB, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      6'd35, 6'd43: begin
        add(S_MADDR, 1'b0, 1'b0, 1'b0, 1'b0);
        add_wait((op == 6'd35) ? S_MRD : S_MWR, wm, tmo_mem);
        if (op == 6'd35 && !tmo_mem) add(S_MWB, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      6'd4, 6'd7: add(S_BR, 1'b0, 1'b0, 1'b0, 1'b0);
      6'd2: add(S_JMP, 1'b0, 1'b0, 1'b0, 1'b0);
      6'd9: begin
        add(S_IEX, 1'b0, 1'b0, 1'b0, 1'b0);
        add(S_IWB, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      default: for (int i = 0; i < 3; i++) add(S_HALT, 1'b0, 1'b0, 1'b1, 1'b0);
    endcase
  endtask

  // Walks the plan one cycle per step; called right after a rising edge.
  task automatic execute(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic zero, input int upto);
    step_t s;
    logic mr;
    logic [24:0] exp_v, got_v;
    for (int i = 0; i < plan.size(); i++) begin
      s = plan[i];
      #1;
      if (i == 0) begin
        opcode = op; funct = fn; instr_zero = zero;
      end
      mr = s.waiting ? s.last : 1'($urandom);
      mem_ready = mr;
      #3;
      exp_v = {s.st, s.ei, s.et, expect_ctl(s.st, op, fn, zero, mr)};
      got_v = {state, err_illegal, err_timeout, ctl};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s step %0d: got {state,ill,tmo,ctl}=%h expected %h", name, i, got_v, exp_v);
      end
      if (i == upto - 1) return;
      @(posedge clk);
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int wi, input int wm,
                           input bit tmo_if, input bit tmo_mem);
    build_plan(op, zero, wi, wm, tmo_if, tmo_mem);
    execute(name, op, fn, zero, -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({state, err_illegal, err_timeout, ctl} !== 25'd0) begin
      errors++;
      $display("FAIL %s: got state=%0d ill=%b tmo=%b ctl=%h expected all zero",
               name, state, err_illegal, err_timeout, ctl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0; instr_zero = 1'b1;
    repeat (2) @(posedge clk);
    #2 check_idle("reset_ready_hi");
    mem_ready = 1'b0; opcode = 6'd43;
    #3 check_idle("reset_ready_lo");
  endtask

  task automatic test_addiu();
    run_instr("addiu", 6'd9, 6'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr("addiu_if_wait", 6'd9, 6'($urandom), 1'b0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", 6'd35, 6'($urandom), 1'b0, 0, 3, 1'b0, 1'b0);
    run_instr("sw_wait2", 6'd43, 6'($urandom), 1'b0, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_rtype();
    run_instr("sll", 6'd0, 6'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr("addu", 6'd0, 6'd33, 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr("srl", 6'd0, 6'd2, 1'b0, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_nop_branch();
    run_instr("nop", 6'd0, 6'd0, 1'b1, 0, 0, 1'b0, 1'b0);
    run_instr("bgtz", 6'd7, 6'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr("beq", 6'd4, 6'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
    run_instr("j", 6'd2, 6'($urandom), 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    logic zero;
    for (int n = 0; n < 40; n++) begin
      zero = 1'b0;
      fn = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 1) * 2) : 6'($urandom);
      case ($urandom_range(0, 7))
        0: begin op = 6'd0; fn = 6'd0; zero = 1'b1; end
        1: op = 6'd0;
        2: op = 6'd35;
        3: op = 6'd43;
        4: op = 6'd4;
        5: op = 6'd7;
        6: op = 6'd2;
        default: op = 6'd9;
      endcase
      run_instr("random", op, fn, zero, $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, 1'b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr("if_timeout", 6'd2, 6'd0, 1'b0, TMO, 0, 1'b1, 1'b0);
    do_reset();
    run_instr("if_ready_at_limit", 6'd2, 6'd0, 1'b0, TMO - 1, 0, 1'b0, 1'b0);
    run_instr("sw_ready_at_limit", 6'd43, 6'd5, 1'b0, 0, TMO - 1, 1'b0, 1'b0);
    run_instr("lw_timeout", 6'd35, 6'd5, 1'b0, 0, TMO, 1'b0, 1'b1);
    do_reset();
  endtask

  task automatic test_mid_reset();
    build_plan(6'd9, 1'b0, 0, 0, 1'b0, 1'b0);
    execute("mid_addiu", 6'd9, 6'd0, 1'b0, 4);
    #1 rst = 1'b0;
    #1 check_idle("mid_reset_regwrite");
    do_reset();
    build_plan(6'd43, 1'b0, 0, 3, 1'b0, 1'b0);
    execute("mid_sw", 6'd43, 6'd0, 1'b0, 5);
    #1 rst = 1'b0;
    #1 check_idle("mid_reset_memwrite");
    do_reset();
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) op = 6'd63;
      else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr("illegal", op, 6'($urandom), 1'b0, $urandom_range(0, 2), 0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1 check_idle("illegal_async_reset");
      do_reset();
    end
  endtask

  initial begin
    mem_ready = 1'b0;
    test_reset();
    do_reset();
    test_addiu();
    test_lw_wait();
    test_rtype();
    test_nop_branch();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    test_illegal();
    run_instr("after_errors", 6'd9, 6'd1, 1'b0, 0, 0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
